// File: rtl/image_stage_sequencer.sv
// Runs the mirror, gray and filter engines one at a time on a shared 64x64 image memory port.
// Define STAGE_WATCHDOG_EN to add a per-stage RUN watchdog with a sticky error flag.
module image_stage_sequencer #(
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned PIX_W       = 24,
  parameter int unsigned WDOG_CYCLES = 65535
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [2:0]          stage_mask,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [1:0]          stage_sel,
  output logic [2:0]          eng_go,
  input  logic [2:0]          eng_done,
  input  logic [3*ADDR_W-1:0] eng_row,
  input  logic [3*ADDR_W-1:0] eng_col,
  input  logic [2:0]          eng_we,
  input  logic [3*PIX_W-1:0]  eng_pix,
  output logic [ADDR_W-1:0]   mem_row,
  output logic [ADDR_W-1:0]   mem_col,
  output logic                mem_we,
  output logic [PIX_W-1:0]    mem_pix
);

  typedef enum logic [2:0] {StIdle, StLaunch, StRun, StNext, StDone, StErr} state_e;

  state_e     state_q;
  logic [2:0] pending_q;
  logic [2:0] done_q;
  logic [2:0] go_q;
  logic [1:0] cur_q;
  logic       busy_q;
  logic       done_pulse_q;
  logic       done_edge;
  logic [2:0] remaining;

  // Fixed mirror -> gray -> filter order falls out of always picking the lowest pending bit.
  function automatic logic [1:0] lowest(input logic [2:0] m);
    if (m[0]) return 2'd0;
    if (m[1]) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] i);
    return 3'b001 << i;
  endfunction

  assign done_edge = eng_done[cur_q] & ~done_q[cur_q];
  assign remaining = pending_q & ~onehot(cur_q);

`ifdef STAGE_WATCHDOG_EN
  localparam int unsigned WdogW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WdogW-1:0] WdogLast = WdogW'(WDOG_CYCLES - 1);

  logic [WdogW-1:0] wdog_q;
  logic             error_q;
  logic             wdog_expired;

  assign wdog_expired = (wdog_q == WdogLast);
  assign error        = error_q;
`else
  localparam int unsigned UnusedWdogCycles = WDOG_CYCLES;

  assign error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      pending_q    <= '0;
      done_q       <= '0;
      go_q         <= '0;
      cur_q        <= '0;
      busy_q       <= 1'b0;
      done_pulse_q <= 1'b0;
`ifdef STAGE_WATCHDOG_EN
      wdog_q       <= '0;
      error_q      <= 1'b0;
`endif
    end else begin
      done_q       <= eng_done;
      go_q         <= '0;
      done_pulse_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
`ifdef STAGE_WATCHDOG_EN
            error_q <= 1'b0;
`endif
            if (stage_mask != 3'b000) begin
              pending_q <= stage_mask;
              cur_q     <= lowest(stage_mask);
              go_q      <= onehot(lowest(stage_mask));
              busy_q    <= 1'b1;
              state_q   <= StLaunch;
            end else begin
              done_pulse_q <= 1'b1;
              state_q      <= StDone;
            end
          end
        end
        StLaunch: begin
`ifdef STAGE_WATCHDOG_EN
          wdog_q  <= '0;
`endif
          state_q <= StRun;
        end
        StRun: begin
          if (done_edge) begin
            state_q <= StNext;
`ifdef STAGE_WATCHDOG_EN
          end else if (wdog_expired) begin
            pending_q <= '0;
            busy_q    <= 1'b0;
            state_q   <= StErr;
          end else begin
            wdog_q <= wdog_q + 1'b1;
`endif
          end
        end
        StNext: begin
          pending_q <= remaining;
          if (remaining != 3'b000) begin
            cur_q   <= lowest(remaining);
            go_q    <= onehot(lowest(remaining));
            state_q <= StLaunch;
          end else begin
            busy_q       <= 1'b0;
            done_pulse_q <= 1'b1;
            state_q      <= StDone;
          end
        end
        StDone: state_q <= StIdle;
        StErr: begin
`ifdef STAGE_WATCHDOG_EN
          error_q <= 1'b1;
`endif
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Only the engine being run may drive the memory port; everything else is held at zero.
  always_comb begin
    mem_row = '0;
    mem_col = '0;
    mem_we  = 1'b0;
    mem_pix = '0;
    if (state_q == StRun) begin
      for (int k = 0; k < 3; k++) begin
        if (cur_q == 2'(k)) begin
          mem_row = eng_row[k*ADDR_W +: ADDR_W];
          mem_col = eng_col[k*ADDR_W +: ADDR_W];
          mem_we  = eng_we[k];
          mem_pix = eng_pix[k*PIX_W +: PIX_W];
        end
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_pulse_q;
  assign stage_sel = cur_q;
  assign eng_go    = go_q;

endmodule

// File: tb/tb_image_stage_sequencer.sv
// Scoreboard bench for image_stage_sequencer: launch/done events are queued with their cycle
// and checked as they appear; the shared memory bus is checked against the running engine.
module tb_image_stage_sequencer;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned PIX_W  = 24;
  localparam int unsigned WDOG   = 16;
`ifdef STAGE_WATCHDOG_EN
  localparam int HOLD = 8;
`else
  localparam int HOLD = 30;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [2:0]          stage_mask = 3'b000;
  logic                busy, done, error;
  logic [1:0]          stage_sel;
  logic [2:0]          eng_go;
  logic [2:0]          eng_done = 3'b000;
  logic [3*ADDR_W-1:0] eng_row = '0;
  logic [3*ADDR_W-1:0] eng_col = '0;
  logic [2:0]          eng_we = 3'b000;
  logic [3*PIX_W-1:0]  eng_pix = '0;
  logic [ADDR_W-1:0]   mem_row, mem_col;
  logic                mem_we;
  logic [PIX_W-1:0]    mem_pix;

  image_stage_sequencer #(
    .ADDR_W     (ADDR_W),
    .PIX_W      (PIX_W),
    .WDOG_CYCLES(WDOG)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stage_mask(stage_mask),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .stage_sel (stage_sel),
    .eng_go    (eng_go),
    .eng_done  (eng_done),
    .eng_row   (eng_row),
    .eng_col   (eng_col),
    .eng_we    (eng_we),
    .eng_pix   (eng_pix),
    .mem_row   (mem_row),
    .mem_col   (mem_col),
    .mem_we    (mem_we),
    .mem_pix   (mem_pix)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         kind;  // 0 launch, 1 done pulse
    logic [2:0] go;
    int         cyc;
  } ev_t;
  ev_t exp_q[$];

  int         delay[3]   = '{10, 20, 30};
  int         done_at[3] = '{-1, -1, -1};
  logic [2:0] manual     = 3'b000;
  logic [2:0] man_done   = 3'b000;

  // Engine models: done rises delay[k] cycles after eng_go; write traffic is random on all engines.
  always @(posedge clk) begin
    logic [95:0] r;
    #2;
    for (int k = 0; k < 3; k++) begin
      if (manual[k]) begin
        eng_done[k] = man_done[k];
      end else if (eng_go[k]) begin
        eng_done[k] = 1'b0;
        done_at[k]  = cyc + delay[k];
      end else if (cyc == done_at[k]) begin
        eng_done[k] = 1'b1;
      end
    end
    eng_we = 3'($urandom);
    r = {$urandom, $urandom, $urandom};
    eng_pix = r[71:0];
    r = {$urandom, $urandom, $urandom};
    eng_row = r[17:0];
    eng_col = r[35:18];
  end

  // Monitor: bus ownership model plus scoreboard pops for eng_go and done.
  logic       in_run    = 1'b0;
  int         sel       = 0;
  int         run_cnt   = 0;
  logic [2:0] prev_done = 3'b000;

  always @(negedge clk) begin
    logic              exp_we;
    logic [ADDR_W-1:0] er, ec;
    logic [PIX_W-1:0]  ep;
    ev_t               e;
    int                idx;
    exp_we = in_run ? eng_we[sel] : 1'b0;
    er     = in_run ? eng_row[sel*ADDR_W +: ADDR_W] : '0;
    ec     = in_run ? eng_col[sel*ADDR_W +: ADDR_W] : '0;
    ep     = in_run ? eng_pix[sel*PIX_W +: PIX_W] : '0;
    n_checks++;
    if (mem_we !== exp_we || mem_row !== er || mem_col !== ec || mem_pix !== ep) begin
      n_fail++;
      $display("FAIL bus cyc=%0d got we=%b row=%0d col=%0d pix=%h expected we=%b row=%0d col=%0d pix=%h",
               cyc, mem_we, mem_row, mem_col, mem_pix, exp_we, er, ec, ep);
    end
    if (eng_go !== 3'b000) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_go cyc=%0d got eng_go=%b expected none", cyc, eng_go);
      end else begin
        e   = exp_q.pop_front();
        idx = (e.go == 3'b100) ? 2 : (e.go == 3'b010) ? 1 : 0;
        if (e.kind != 0 || eng_go !== e.go || cyc != e.cyc || stage_sel !== 2'(idx)) begin
          n_fail++;
          $display("FAIL launch got eng_go=%b cyc=%0d stage_sel=%0d expected kind=%0d eng_go=%b cyc=%0d stage_sel=%0d",
                   eng_go, cyc, stage_sel, e.kind, e.go, e.cyc, idx);
        end
      end
    end
    if (done !== 1'b0) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done cyc=%0d got done=%b expected 0", cyc, done);
      end else begin
        e = exp_q.pop_front();
        if (e.kind != 1 || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL done_pulse got cyc=%0d expected kind=%0d cyc=%0d", cyc, e.kind, e.cyc);
        end
      end
    end
    if (rst) begin
      in_run = 1'b0;
    end else if (in_run) begin
      if (eng_done[sel] && !prev_done[sel]) begin
        in_run = 1'b0;
      end else begin
        run_cnt++;
`ifdef STAGE_WATCHDOG_EN
        if (run_cnt == WDOG) in_run = 1'b0;
`endif
      end
    end
    if (!rst && eng_go != 3'b000) begin
      in_run  = 1'b1;
      sel     = eng_go[2] ? 2 : eng_go[1] ? 1 : 0;
      run_cnt = 0;
    end
    prev_done = eng_done;
  end

  task automatic do_start(input logic [2:0] mask, output int n);
    @(posedge clk); #1;
    start      = 1'b1;
    stage_mask = mask;
    n          = cyc;
    @(posedge clk); #1;
    start      = 1'b0;
    stage_mask = 3'b000;
  endtask

  task automatic push_ev(input int kind, input logic [2:0] go, input int c);
    ev_t e;
    e.kind = kind;
    e.go   = go;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic push_seq(input logic [2:0] mask, input int n);
    int t;
    t = n + 1;
    for (int k = 0; k < 3; k++) begin
      if (mask[k]) begin
        push_ev(0, 3'(1 << k), t);
        t = t + delay[k] + 2;
      end
    end
    push_ev(1, 3'b000, t);
  endtask

  task automatic wait_neg(input int c);
    @(negedge clk);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_pos(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_drain(input int budget, input string name);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      @(posedge clk); #1;
      i++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout got pending=%0d expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_status got busy=%b done=%b error=%b expected 0 0 0", busy, done, error);
      end
      n_checks++;
      if (stage_sel !== 2'd0 || eng_go !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_ctrl got stage_sel=%0d eng_go=%b expected 0 000", stage_sel, eng_go);
      end
    end
  endtask

  task automatic test_full();
    int n;
    delay = '{10, 20, 30};
    do_start(3'b111, n);
    push_seq(3'b111, n);
    wait_neg(n + 1);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL full_busy got %b expected 1", busy);
    end
    wait_drain(200, "full");
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL full_busy_end got %b expected 0", busy);
    end
  endtask

  task automatic test_mask_101();
    int n;
    delay = '{5, 9, 7};
    do_start(3'b101, n);
    push_seq(3'b101, n);
    wait_drain(100, "mask101");
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mask101_busy_end got %b expected 0", busy);
    end
  endtask

  task automatic test_mask_zero();
    int n;
    do_start(3'b000, n);
    push_seq(3'b000, n);
    wait_neg(n + 1);
    n_checks++;
    if (busy !== 1'b0 || eng_go !== 3'b000) begin
      n_fail++;
      $display("FAIL mask0_quiet got busy=%b eng_go=%b expected 0 000", busy, eng_go);
    end
    wait_drain(10, "mask0");
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mask0_busy got %b expected 0", busy);
    end
  endtask

  task automatic test_held_done();
    int n;
    manual[1]   = 1'b1;
    man_done[1] = 1'b1;
    repeat (3) @(posedge clk);
    do_start(3'b010, n);
    push_ev(0, 3'b010, n + 1);
    push_ev(1, 3'b000, n + 17);
    wait_pos(n + 5);
    start      = 1'b1;
    stage_mask = 3'b111;
    @(posedge clk); #1;
    start      = 1'b0;
    stage_mask = 3'b000;
    wait_neg(n + 10);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL held_busy got %b expected 1", busy);
    end
    wait_pos(n + 12);
    man_done[1] = 1'b0;
    wait_pos(n + 15);
    man_done[1] = 1'b1;
    wait_drain(40, "held");
    manual[1] = 1'b0;
  endtask

  task automatic test_rst_mid_run();
    int n;
    manual[0]   = 1'b1;
    man_done[0] = 1'b0;
    do_start(3'b001, n);
    push_ev(0, 3'b001, n + 1);
    wait_neg(n + HOLD);
    n_checks++;
    if (busy !== 1'b1 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL hang_status got busy=%b error=%b expected 1 0", busy, error);
    end
    wait_pos(n + HOLD + 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || eng_go !== 3'b000 || stage_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL rst_mid_run got we=%b busy=%b eng_go=%b stage_sel=%0d expected 0 0 000 0",
               mem_we, busy, eng_go, stage_sel);
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_idle got pending=%0d busy=%b expected 0 0", exp_q.size(), busy);
      exp_q.delete();
    end
    manual[0] = 1'b0;
  endtask

`ifdef STAGE_WATCHDOG_EN
  task automatic test_watchdog();
    int n, n2;
    manual   = 3'b011;
    man_done = 3'b000;
    do_start(3'b011, n);
    push_ev(0, 3'b001, n + 1);
    wait_neg(n + 18);
    n_checks++;
    if (error !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wdog_err_state got error=%b busy=%b expected 0 0", error, busy);
    end
    @(negedge clk);
    n_checks++;
    if (error !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wdog_error got error=%b busy=%b expected 1 0", error, busy);
    end
    wait_neg(n + 30);
    n_checks++;
    if (error !== 1'b1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL wdog_sticky got error=%b pending=%0d expected 1 0", error, exp_q.size());
      exp_q.delete();
    end
    do_start(3'b000, n2);
    push_ev(1, 3'b000, n2 + 1);
    wait_neg(n2 + 1);
    n_checks++;
    if (error !== 1'b0) begin
      n_fail++;
      $display("FAIL wdog_clear got error=%b expected 0", error);
    end
    wait_drain(10, "wdog_clear");
    manual = 3'b000;
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL global_timeout got time=%0t expected finish earlier", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_full();
    test_mask_101();
    test_mask_zero();
    test_held_done();
    test_rst_mid_run();
`ifdef STAGE_WATCHDOG_EN
    test_watchdog();
`endif
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
